// File: rtl/sound_length_sequencer_if.sv
// Bundle between the sound register file and the length sequencer.
// Register-file side is master, sequencer side is slave.
interface sound_length_sequencer_if;
  logic       master_en;
  logic [3:0] trigger;
  logic [3:0] dont_loop;
  logic [3:0] dac_en;
  logic       sweep_overflow;
  logic [5:0] ch1_length_data;
  logic [5:0] ch2_length_data;
  logic [7:0] ch3_length_data;
  logic [5:0] ch4_length_data;
  logic [3:0] ch_active;
  logic [3:0] ch_reset;
  logic       sweep_tick;
  logic       env_tick;
  logic [2:0] step;
  logic [7:0] sound_status;

  modport master (
    output master_en,
    output trigger,
    output dont_loop,
    output dac_en,
    output sweep_overflow,
    output ch1_length_data,
    output ch2_length_data,
    output ch3_length_data,
    output ch4_length_data,
    input  ch_active,
    input  ch_reset,
    input  sweep_tick,
    input  env_tick,
    input  step,
    input  sound_status
  );

  modport slave (
    input  master_en,
    input  trigger,
    input  dont_loop,
    input  dac_en,
    input  sweep_overflow,
    input  ch1_length_data,
    input  ch2_length_data,
    input  ch3_length_data,
    input  ch4_length_data,
    output ch_active,
    output ch_reset,
    output sweep_tick,
    output env_tick,
    output step,
    output sound_status
  );
endinterface

// File: rtl/sound_length_sequencer.sv
// 256 Hz frame sequencer: sweep/envelope strobes, per-channel
// length countdown, trigger restart and NR52-style status.
module sound_length_sequencer #(
  parameter int SWEEP_DIV = 2,
  parameter int ENV_DIV   = 4
) (
  input logic                     length_cntrl_clk,
  input logic                     reset,
  sound_length_sequencer_if.slave bus
);

  localparam logic [2:0] SWEEP_M = 3'(SWEEP_DIV - 1);
  localparam logic [2:0] ENV_M   = 3'(ENV_DIV - 1);

  logic [2:0] step_q;
  logic [2:0] step_d;
  logic       sweep_q;
  logic       sweep_d;
  logic       env_q;
  logic       env_d;
  logic [3:0] act_q;
  logic [3:0] act_d;
  logic [3:0] rst_q;
  logic [3:0] rst_d;
  logic [8:0] len_q [4];
  logic [8:0] len_d [4];
  logic [8:0] load  [4];

  // Length registers count down from (max - data); data 0 means full length.
  always_comb begin
    load[0] = 9'd64  - {3'b000, bus.ch1_length_data};
    load[1] = 9'd64  - {3'b000, bus.ch2_length_data};
    load[2] = 9'd256 - {1'b0, bus.ch3_length_data};
    load[3] = 9'd64  - {3'b000, bus.ch4_length_data};
  end

  always_comb begin
    step_d  = 3'd0;
    sweep_d = 1'b0;
    env_d   = 1'b0;
    if (bus.master_en) begin
      step_d  = step_q + 3'd1;
      sweep_d = (step_q & SWEEP_M) == SWEEP_M;
      env_d   = (step_q & ENV_M) == ENV_M;
    end
  end

  always_comb begin
    act_d = act_q;
    rst_d = '0;
    for (int i = 0; i < 4; i++) begin
      len_d[i] = len_q[i];
      if (!bus.master_en) begin
        len_d[i] = '0;
        act_d[i] = 1'b0;
      end else if (bus.trigger[i]) begin
        len_d[i] = load[i];
        act_d[i] = bus.dac_en[i];
        rst_d[i] = 1'b1;
      end else if (!bus.dac_en[i]) begin
        act_d[i] = 1'b0;
      end else if (i == 0 && bus.sweep_overflow) begin
        act_d[i] = 1'b0;
      end else if (act_q[i] && bus.dont_loop[i]
                   && len_q[i] != 9'd0) begin
        len_d[i] = len_q[i] - 9'd1;
        if (len_q[i] == 9'd1)
          act_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge length_cntrl_clk) begin
    if (reset) begin
      step_q  <= '0;
      sweep_q <= 1'b0;
      env_q   <= 1'b0;
      act_q   <= '0;
      rst_q   <= '0;
      for (int i = 0; i < 4; i++)
        len_q[i] <= '0;
    end else begin
      step_q  <= step_d;
      sweep_q <= sweep_d;
      env_q   <= env_d;
      act_q   <= act_d;
      rst_q   <= rst_d;
      for (int i = 0; i < 4; i++)
        len_q[i] <= len_d[i];
    end
  end

  assign bus.step         = step_q;
  assign bus.sweep_tick   = sweep_q;
  assign bus.env_tick     = env_q;
  assign bus.ch_active    = act_q;
  assign bus.ch_reset     = rst_q;
  assign bus.sound_status = {bus.master_en, 3'b111, act_q};

endmodule
